// File: rtl/matrix_slot_writer_pkg.sv
// rtl/matrix_slot_writer_pkg.sv - shared matrix-storage slot layout constants, writer states, slot base helper
//
// Package matrix_storage_pkg: no ports.
//   SLOT_WORDS / offsets describe the fixed slot layout in the storage BRAM:
//     base+HDR_OFFSET  : {rows, cols, 16'h0}  (written last, marks slot occupied)
//     base+NAME_OFFSET : name bytes 0..3, base+NAME_OFFSET+1 : name bytes 4..7
//     base+DATA_OFFSET : first row-major element
//   slot_base(id) returns id*SLOT_WORDS at ADDR_W bits (fits for ids 0..7).

package matrix_storage_pkg;

    localparam int SLOT_WORDS  = 1152;
    localparam int HDR_OFFSET  = 0;
    localparam int NAME_OFFSET = 1;
    localparam int DATA_OFFSET = 3;
    localparam int MAX_ELEMS   = SLOT_WORDS - DATA_OFFSET;
    localparam int ADDR_W      = 14;
    localparam int NAME_BYTES  = 8;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_NAME0,
        WR_NAME1,
        WR_STREAM,
        WR_COMMIT,
        WR_DONE
    } wr_state_t;

    function automatic logic [ADDR_W-1:0] slot_base(input logic [2:0] id);
        return ADDR_W'(id) * ADDR_W'(SLOT_WORDS);
    endfunction

endpackage

// File: rtl/matrix_slot_writer_if.sv
// rtl/matrix_slot_writer_if.sv - producer-to-writer request/stream handshake and BRAM write port bundle
//
// Signals:
//   write_request/write_ready           : start-of-matrix handshake
//   matrix_id, actual_rows/cols, name   : request fields, latched on accept
//   data_in/data_valid/writer_ready     : element stream
//   write_done, error                   : completion flag / reject pulse
//   bram_we/bram_addr/bram_din          : registered storage BRAM write port
// Modports: master = producer side, slave = slot writer side.

interface matrix_slot_writer_if;
    import matrix_storage_pkg::*;

    logic                write_request;
    logic                write_ready;
    logic [2:0]          matrix_id;
    logic [7:0]          actual_rows;
    logic [7:0]          actual_cols;
    logic [7:0]          matrix_name [0:NAME_BYTES-1];
    logic [31:0]         data_in;
    logic                data_valid;
    logic                writer_ready;
    logic                write_done;
    logic                error;
    logic                bram_we;
    logic [ADDR_W-1:0]   bram_addr;
    logic [31:0]         bram_din;

    modport master (
        output write_request, matrix_id, actual_rows, actual_cols, matrix_name,
               data_in, data_valid,
        input  write_ready, writer_ready, write_done, error,
               bram_we, bram_addr, bram_din
    );

    modport slave (
        input  write_request, matrix_id, actual_rows, actual_cols, matrix_name,
               data_in, data_valid,
        output write_ready, writer_ready, write_done, error,
               bram_we, bram_addr, bram_din
    );

endinterface

// File: rtl/matrix_slot_writer.sv
// rtl/matrix_slot_writer.sv - commits one requested matrix into its storage slot, header word last
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : matrix_slot_writer_if.slave (request fields, element stream,
//          status flags, registered BRAM write port)

module matrix_slot_writer
    import matrix_storage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    matrix_slot_writer_if.slave   bus
);

    wr_state_t          state_q;
    wr_state_t          state_d;

    logic [ADDR_W-1:0]  base_q;
    logic [7:0]         rows_q;
    logic [7:0]         cols_q;
    logic [31:0]        name_lo_q;
    logic [31:0]        name_hi_q;
    logic [15:0]        total_q;
    logic [15:0]        count_q;
    logic               write_done_q;
    logic               error_q;
    logic               bram_we_q;
    logic [ADDR_W-1:0]  bram_addr_q;
    logic [31:0]        bram_din_q;

    logic               accept;
    logic [15:0]        req_total;
    logic               req_bad;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [31:0]        wr_data;
    logic               count_inc;

    // Request screening happens on the raw inputs in the accept cycle so a
    // bad request never leaves IDLE.
    assign accept    = bus.write_request && (state_q == WR_IDLE);
    assign req_total = 16'(bus.actual_rows) * 16'(bus.actual_cols);
    assign req_bad   = (bus.actual_rows == 8'd0) || (bus.actual_cols == 8'd0) ||
                       (req_total > 16'(MAX_ELEMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        count_inc = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (accept && !req_bad) begin
                    state_d = WR_NAME0;
                end
            end
            WR_NAME0: begin
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_W'(NAME_OFFSET);
                wr_data = name_lo_q;
                state_d = WR_NAME1;
            end
            WR_NAME1: begin
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_W'(NAME_OFFSET + 1);
                wr_data = name_hi_q;
                state_d = WR_STREAM;
            end
            WR_STREAM: begin
                if (bus.data_valid) begin
                    wr_en     = 1'b1;
                    wr_addr   = base_q + ADDR_W'(DATA_OFFSET) + count_q[ADDR_W-1:0];
                    wr_data   = bus.data_in;
                    count_inc = 1'b1;
                    if (count_q + 16'd1 == total_q) begin
                        state_d = WR_COMMIT;
                    end
                end
            end
            WR_COMMIT: begin
                // Header goes in only after every element has landed, so
                // readers never see a half-filled slot as occupied.
                wr_en   = 1'b1;
                wr_addr = base_q + ADDR_W'(HDR_OFFSET);
                wr_data = {rows_q, cols_q, 16'h0000};
                state_d = WR_DONE;
            end
            WR_DONE: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q       <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            name_lo_q    <= '0;
            name_hi_q    <= '0;
            total_q      <= '0;
            count_q      <= '0;
            write_done_q <= 1'b0;
            error_q      <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
        end else begin
            error_q <= accept && req_bad;

            if (accept) begin
                base_q       <= slot_base(bus.matrix_id);
                rows_q       <= bus.actual_rows;
                cols_q       <= bus.actual_cols;
                name_lo_q    <= {bus.matrix_name[0], bus.matrix_name[1],
                                 bus.matrix_name[2], bus.matrix_name[3]};
                name_hi_q    <= {bus.matrix_name[4], bus.matrix_name[5],
                                 bus.matrix_name[6], bus.matrix_name[7]};
                total_q      <= req_total;
                count_q      <= '0;
                write_done_q <= 1'b0;
            end else if (count_inc) begin
                count_q <= count_q + 16'd1;
            end

            if (state_q == WR_COMMIT) begin
                write_done_q <= 1'b1;
            end

            bram_we_q <= wr_en;
            if (wr_en) begin
                bram_addr_q <= wr_addr;
                bram_din_q  <= wr_data;
            end
        end
    end

    assign bus.write_ready  = (state_q == WR_IDLE);
    assign bus.writer_ready = (state_q == WR_STREAM) || (state_q == WR_COMMIT) ||
                              (state_q == WR_DONE);
    assign bus.write_done   = write_done_q;
    assign bus.error        = error_q;
    assign bus.bram_we      = bram_we_q;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.bram_din     = bram_din_q;

endmodule

// File: tb/tb_matrix_slot_writer.sv
// tb/tb_matrix_slot_writer.sv - directed self-checking bench for matrix_slot_writer

module tb_matrix_slot_writer;
    import matrix_storage_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [ADDR_W-1:0] wa [$];
    logic [31:0]       wd [$];

    matrix_slot_writer_if bus();

    matrix_slot_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.bram_we === 1'b1) begin
            wa.push_back(bus.bram_addr);
            wd.push_back(bus.bram_din);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int idx, input int addr, input logic [31:0] data);
        if (idx >= wa.size()) begin
            check({tag, "_missing"}, 32'(wa.size()), 32'(idx + 1));
        end else begin
            check({tag, "_addr"}, 32'(wa[idx]), 32'(addr));
            check({tag, "_data"}, wd[idx], data);
        end
    endtask

    task automatic set_req(input logic [2:0] id, input logic [7:0] r, input logic [7:0] c,
                           input logic [63:0] nm);
        bus.matrix_id   = id;
        bus.actual_rows = r;
        bus.actual_cols = c;
        for (int k = 0; k < 8; k++) begin
            bus.matrix_name[k] = nm[63-8*k -: 8];
        end
    endtask

    task automatic wait_writer_ready();
        for (int k = 0; k < 8 && bus.writer_ready !== 1'b1; k++) begin
            tick();
        end
        check("wait_writer_ready", 32'(bus.writer_ready), 32'd1);
    endtask

    task automatic send(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            bus.data_in    = 32'(start + i);
            bus.data_valid = 1'b1;
            tick();
        end
        bus.data_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] nm;
        int          idx0;
        int          hits;

        tests = 0;
        fails = 0;
        nm    = "ABCDEFGH";
        rst   = 1'b1;
        bus.write_request = 1'b0;
        bus.data_valid    = 1'b0;
        bus.data_in       = '0;
        set_req(3'd0, 8'd0, 8'd0, 64'd0);

        // Reset state
        #1;
        check("rst_write_ready", 32'(bus.write_ready), 32'd1);
        check("rst_writer_ready", 32'(bus.writer_ready), 32'd0);
        check("rst_write_done", 32'(bus.write_done), 32'd0);
        check("rst_error", 32'(bus.error), 32'd0);
        check("rst_bram_we", 32'(bus.bram_we), 32'd0);
        check("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
        check("rst_bram_din", bus.bram_din, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: id=2, 2x3, six back-to-back elements
        idx0 = wa.size();
        set_req(3'd2, 8'd2, 8'd3, nm);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        check("t1_taken_write_ready", 32'(bus.write_ready), 32'd0);
        check("t1_name0_writer_ready", 32'(bus.writer_ready), 32'd0);
        tick();
        check("t1_name0_we", 32'(bus.bram_we), 32'd1);
        check("t1_name0_addr", 32'(bus.bram_addr), 32'd2305);
        tick();
        check("t1_name1_addr", 32'(bus.bram_addr), 32'd2306);
        check("t1_stream_writer_ready", 32'(bus.writer_ready), 32'd1);
        send(6, 10);
        check("t1_commit_write_done", 32'(bus.write_done), 32'd0);
        check("t1_commit_writer_ready", 32'(bus.writer_ready), 32'd1);
        bus.data_valid = 1'b1;
        bus.data_in    = 32'd99;
        tick();
        check("t1_done_write_done", 32'(bus.write_done), 32'd1);
        check("t1_hdr_addr", 32'(bus.bram_addr), 32'd2304);
        check("t1_hdr_din", bus.bram_din, 32'h02030000);
        check("t1_done_writer_ready", 32'(bus.writer_ready), 32'd1);
        tick();
        bus.data_valid = 1'b0;
        check("t1_idle_write_done", 32'(bus.write_done), 32'd1);
        check("t1_idle_write_ready", 32'(bus.write_ready), 32'd1);
        tick();
        check("t1_write_count", 32'(wa.size() - idx0), 32'd9);
        check_wr("t1_w0", idx0 + 0, 2305, 32'h41424344);
        check_wr("t1_w1", idx0 + 1, 2306, 32'h45464748);
        for (int k = 0; k < 6; k++) begin
            check_wr("t1_elem", idx0 + 2 + k, 2307 + k, 32'(10 + k));
        end
        check_wr("t1_hdr", idx0 + 8, 2304, 32'h02030000);

        // 2: same request, data_valid toggled
        idx0 = wa.size();
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        check("t2_accept_clears_done", 32'(bus.write_done), 32'd0);
        wait_writer_ready();
        for (int i = 0; i < 12; i++) begin
            bus.data_valid = (i % 2 == 0);
            bus.data_in    = 32'(20 + i / 2);
            tick();
        end
        bus.data_valid = 1'b0;
        tick();
        tick();
        check("t2_write_done", 32'(bus.write_done), 32'd1);
        check("t2_write_count", 32'(wa.size() - idx0), 32'd9);
        for (int k = 0; k < 6; k++) begin
            check_wr("t2_elem", idx0 + 2 + k, 2307 + k, 32'(20 + k));
        end
        check_wr("t2_hdr", idx0 + 8, 2304, 32'h02030000);

        // 3: rejected requests
        idx0 = wa.size();
        set_req(3'd4, 8'd0, 8'd5, nm);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        check("t3a_error", 32'(bus.error), 32'd1);
        check("t3a_write_ready", 32'(bus.write_ready), 32'd1);
        check("t3a_write_done", 32'(bus.write_done), 32'd0);
        tick();
        check("t3a_error_pulse", 32'(bus.error), 32'd0);
        set_req(3'd4, 8'd40, 8'd40, nm);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        check("t3b_error", 32'(bus.error), 32'd1);
        check("t3b_writer_ready", 32'(bus.writer_ready), 32'd0);
        tick();
        check("t3b_error_pulse", 32'(bus.error), 32'd0);
        check("t3b_write_ready", 32'(bus.write_ready), 32'd1);
        tick();
        check("t3_no_writes", 32'(wa.size() - idx0), 32'd0);

        // 4: request held high through a stream, re-accepted after DONE
        idx0 = wa.size();
        set_req(3'd1, 8'd1, 8'd2, nm);
        bus.write_request = 1'b1;
        tick();
        set_req(3'd5, 8'd0, 8'd0, 64'd0);
        wait_writer_ready();
        check("t4_busy_write_ready", 32'(bus.write_ready), 32'd0);
        send(2, 30);
        tick();
        check("t4_done", 32'(bus.write_done), 32'd1);
        check("t4_hdr_addr", 32'(bus.bram_addr), 32'd1152);
        check("t4_hdr_din", bus.bram_din, 32'h01020000);
        tick();
        check("t4_idle_done_held", 32'(bus.write_done), 32'd1);
        tick();
        bus.write_request = 1'b0;
        check("t4_reaccept_error", 32'(bus.error), 32'd1);
        check("t4_reaccept_clears_done", 32'(bus.write_done), 32'd0);
        tick();
        check("t4_write_count", 32'(wa.size() - idx0), 32'd5);
        check_wr("t4_e0", idx0 + 2, 1155, 32'd30);
        check_wr("t4_e1", idx0 + 3, 1156, 32'd31);

        // 5: reset after 3 of 6 elements, then retry
        set_req(3'd3, 8'd2, 8'd3, nm);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        wait_writer_ready();
        send(3, 40);
        rst = 1'b1;
        #1;
        check("t5_rst_bram_we", 32'(bus.bram_we), 32'd0);
        check("t5_rst_bram_addr", 32'(bus.bram_addr), 32'd0);
        check("t5_rst_bram_din", bus.bram_din, 32'd0);
        check("t5_rst_write_ready", 32'(bus.write_ready), 32'd1);
        check("t5_rst_writer_ready", 32'(bus.writer_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        hits = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] == ADDR_W'(3456)) hits++;
        end
        check("t5_no_header_after_rst", 32'(hits), 32'd0);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        wait_writer_ready();
        send(6, 50);
        tick();
        tick();
        check("t5_retry_done", 32'(bus.write_done), 32'd1);
        hits = 0;
        for (int k = 0; k < wa.size(); k++) begin
            if (wa[k] == ADDR_W'(3456)) hits++;
        end
        check("t5_header_once", 32'(hits), 32'd1);
        check_wr("t5_hdr", wa.size() - 1, 3456, 32'h02030000);
        check_wr("t5_last_elem", wa.size() - 2, 3464, 32'd55);

        // 6: id=7, 33x33 fills the top slot
        idx0 = wa.size();
        set_req(3'd7, 8'd33, 8'd33, nm);
        bus.write_request = 1'b1;
        tick();
        bus.write_request = 1'b0;
        wait_writer_ready();
        send(1089, 0);
        tick();
        tick();
        check("t6_done", 32'(bus.write_done), 32'd1);
        check("t6_write_count", 32'(wa.size() - idx0), 32'd1092);
        check_wr("t6_name0", idx0, 8065, 32'h41424344);
        check_wr("t6_first_elem", idx0 + 2, 8067, 32'd0);
        check_wr("t6_last_elem", wa.size() - 2, 9155, 32'd1088);
        check_wr("t6_hdr", wa.size() - 1, 8064, 32'h21210000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/matrix_slot_writer.md
Name: matrix_slot_writer

Overview:
Responder side of the matrix-storage write protocol. It accepts a write_request carrying slot ID, dimensions and an 8-byte name, then a stream of row-major 32-bit elements, and commits them into the matrix storage BRAM write port using the fixed slot layout. The producers are the generator and input handlers, and the storage BRAM read port is shared with them for empty-slot checks. The header word is written last, so a slot reads as occupied only once its contents are complete.

Parameters:
SLOT_WORDS, 1152, words per slot; slot base address = matrix_id * SLOT_WORDS
MAX_ELEMS, 1149, largest rows*cols accepted (SLOT_WORDS - 3)
ADDR_W, 14, BRAM address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
write_request  in  1  start-of-matrix request; sampled only while write_ready=1
write_ready  out  1  high in IDLE only
matrix_id  in  3  target slot; latched on accept
actual_rows  in  8  rows; latched on accept
actual_cols  in  8  cols; latched on accept
matrix_name  in  8x8 ([0:7])  name bytes; latched on accept
data_in  in  32  element value
data_valid  in  1  element strobe; consumed only when writer_ready=1 in STREAM
writer_ready  out  1  high in STREAM, COMMIT, DONE
write_done  out  1  sticky completion flag; set entering DONE, cleared on next accept or rst
error  out  1  one-cycle pulse on a rejected request
bram_we  out  1  BRAM write enable (registered)
bram_addr  out  ADDR_W  BRAM write address (registered)
bram_din  out  32  BRAM write data (registered)

Behaviour:
- Reset (async, any state): state=IDLE; write_done=0, error=0, bram_we=0, bram_addr=0, bram_din=0; element counter=0. Mid-matrix reset abandons the write. The header is never written, so the slot stays empty.
- Slot layout: base+0 = {rows[7:0], cols[7:0], 16'h0}; base+1 = {name[0],name[1],name[2],name[3]}; base+2 = {name[4]..name[7]}; base+3+i = element i.
- Accept: write_request && write_ready in IDLE. Latch all inputs, clear write_done, compute total = rows*cols (16-bit).
- Reject (same accept cycle): rows==0, cols==0, or total > MAX_ELEMS. Pulse error the next cycle, stay in IDLE, make no BRAM writes, leave write_done at 0.
- FSM:
  - IDLE -> NAME0 on valid accept.
  - NAME0 writes base+1 -> NAME1.
  - NAME1 writes base+2 -> STREAM.
  - STREAM: each cycle with data_valid=1 writes base+3+count and increments count. When count reaches total, go to COMMIT. data_valid=0 simply stalls, with no timeout.
  - COMMIT writes base+0 -> DONE.
  - DONE sets write_done -> IDLE.
- BRAM outputs are registered. A write decided in cycle t appears on bram_we/addr/din in cycle t+1, and bram_we is high for exactly one cycle per word.
- Latency: the first name write is visible 2 cycles after accept. write_done goes high 2 cycles after the last element is accepted.
- writer_ready stays high through COMMIT and DONE, so a producer that re-checks writer_ready after its last element does not stall. data_valid outside STREAM, or beyond total, is ignored with no write.
- write_request while busy is ignored (write_ready=0). write_ready=0 and writer_ready=1 together mark "request taken".
- Address arithmetic: base = matrix_id*SLOT_WORDS, computed ADDR_W wide, with no overflow for IDs 0-7. Any matrix_id, including 0, is accepted.

Decomposition:
- Shared package matrix_storage_pkg: SLOT_WORDS, HDR_OFFSET=0, NAME_OFFSET=1, DATA_OFFSET=3, MAX_ELEMS, ADDR_W, the writer state enum, and a function slot_base(id).
- Single module. No sub-module is warranted; the slot-base multiply is a package function (constant multiplier).

Test Plan:
- Request id=2, rows=2, cols=3, name="ABCDEFGH", then 6 consecutive valid words 10..15:
  - writes to 2305=0x41424344, 2306=0x45464748, and 2307..2312 = 10..15, in that order;
  - then 2304 = 0x02030000;
  - write_done rises 2 cycles after the 6th word and stays high until the next accept.
- Same request with data_valid toggled 1-0-1-0: only the valid cycles write, addresses stay contiguous, and the total remains 6 writes.
- Requests rows=0 cols=5, then rows=40 cols=40 (1600 > 1149): error pulses 1 cycle each, zero BRAM writes, FSM remains in IDLE with write_ready=1.
- write_request held high during a stream: no second accept and latched fields unchanged; a new accept after DONE clears write_done.
- Assert rst after 3 of 6 elements: outputs return to reset values at once, address base+0 is never written, and a later request to the same id completes normally.
- id=7, rows=33, cols=33 (1089 elements): last data word lands at 8064+3+1088=9155, and the header lands at 8064.
